// File: rtl/uart_bcd_scan_if.sv
// Byte-in / digit-out bundle between the UART receiver, the BCD scanner and the 7-seg path.
interface uart_bcd_scan_if;
   logic [7:0] iData;
   logic       iValid;
   logic       oBusy;
   logic       oDone;
   logic [3:0] oDecimal;
   logic [2:0] oDigitSel;

   modport slave  (input iData, iValid, output oBusy, oDone, oDecimal, oDigitSel);
   modport master (output iData, iValid, input oBusy, oDone, oDecimal, oDigitSel);
endinterface

// File: rtl/uart_bcd_scan.sv
// Byte -> 3 BCD digits by sequential double-dabble, then time-multiplexed digit scan.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading-zero hundreds/tens slots.
module uart_bcd_scan #(
   parameter int SCAN_DIV = 50000
) (
   input  logic            iClk,
   input  logic            iRst,
   uart_bcd_scan_if.slave  bus
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {IDLE, CONV} state_e;

   state_e          state_q, state_d;
   logic [7:0]      bin_q, bin_d;
   logic [11:0]     bcd_q, bcd_d;
   logic [2:0]      bit_q, bit_d;
   logic            done_q, done_d;
   logic [11:0]     disp_q, disp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [2:0]      sel_q, sel_d;
   logic [3:0]      dec_q, dec_d;
   logic [11:0]     adj;
   logic [19:0]     shifted;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         bit_q   <= '0;
         done_q  <= 1'b0;
         disp_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         sel_q   <= 3'b110;
         dec_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         bit_q   <= bit_d;
         done_q  <= done_d;
         disp_q  <= disp_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         dec_q   <= dec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      bit_d   = bit_q;
      done_d  = 1'b0;
      disp_d  = disp_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      dec_d   = dec_q;

      adj = bcd_q;
      for (int i = 0; i < 3; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      shifted = {adj, bin_q} << 1;

      case (state_q)
         // The oDone cycle also refuses new bytes even though oBusy is already low.
         IDLE: if (bus.iValid && !done_q) begin
            bin_d   = bus.iData;
            bcd_d   = '0;
            bit_d   = '0;
            state_d = CONV;
         end
         CONV: begin
            bcd_d = shifted[19:8];
            bin_d = shifted[7:0];
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
               state_d = IDLE;
               disp_d  = shifted[19:8];
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (cnt_q == CW'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      // Select and digit both come from the next idx and next display value so they stay aligned.
      sel_d = ~(3'b001 << idx_d);
      case (idx_d)
         2'd0:    dec_d = disp_d[3:0];
         2'd1:    dec_d = disp_d[7:4];
         default: dec_d = disp_d[11:8];
      endcase
`ifdef LEAD_ZERO_BLANK_EN
      if ((idx_d == 2'd2 && disp_d[11:8] == 4'd0) ||
          (idx_d == 2'd1 && disp_d[11:4] == 8'd0)) begin
         sel_d = 3'b111;
         dec_d = 4'd0;
      end
`else
`endif
   end

   assign bus.oBusy     = (state_q == CONV);
   assign bus.oDone     = done_q;
   assign bus.oDecimal  = dec_q;
   assign bus.oDigitSel = sel_q;
endmodule

// File: tb/tb_uart_bcd_scan.sv
// Randomized self-checking bench for uart_bcd_scan against an arithmetic digit/scan model.
module tb_uart_bcd_scan;
   localparam int DIV = 4;

   logic iClk = 1'b0;
   logic iRst = 1'b1;
   int   vecs = 0;
   int   errs = 0;
   int   tcyc = 0;
   int   shown = 0;

   uart_bcd_scan_if bus();

   uart_bcd_scan #(.SCAN_DIV(DIV)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));

   always #5 iClk = ~iClk;

   // Edges elapsed since the last reset edge; the scan slot follows directly from it.
   always @(posedge iClk) begin
      if (iRst) tcyc <= 0;
      else      tcyc <= tcyc + 1;
   end

   function automatic logic [2:0] m_sel(input int t, input int v);
      int idx;
      idx = (t / DIV) % 3;
`ifdef LEAD_ZERO_BLANK_EN
      if ((idx == 2 && v / 100 == 0) || (idx == 1 && v / 10 == 0)) return 3'b111;
`endif
      return ~(3'b001 << idx);
   endfunction

   function automatic logic [3:0] m_dec(input int t, input int v);
      int idx;
      int d;
      idx = (t / DIV) % 3;
      d = (idx == 0) ? v % 10 : (idx == 1) ? (v / 10) % 10 : v / 100;
`ifdef LEAD_ZERO_BLANK_EN
      if ((idx == 2 && v / 100 == 0) || (idx == 1 && v / 10 == 0)) d = 0;
`endif
      return 4'(d);
   endfunction

   // Runs one conversion with inline timing checks; optionally fires ignored strobes
   // mid-conversion and in the oDone cycle.
   task automatic run_conv(input logic [7:0] v, input bit drop_mid, input bit drop_done);
      @(negedge iClk);
      bus.iData = v; bus.iValid = 1'b1;
      @(posedge iClk);
      for (int k = 0; k < 8; k++) begin
         @(negedge iClk);
         vecs++; if (bus.oBusy !== 1'b1) begin errs++; $display("FAIL busy v=%0d k=%0d got %b want 1", v, k, bus.oBusy); end
         vecs++; if (bus.oDone !== 1'b0) begin errs++; $display("FAIL done_early v=%0d k=%0d got %b want 0", v, k, bus.oDone); end
         vecs++; if (bus.oDigitSel !== m_sel(tcyc, shown)) begin errs++; $display("FAIL sel_conv t=%0d got %b want %b", tcyc, bus.oDigitSel, m_sel(tcyc, shown)); end
         vecs++; if (bus.oDecimal !== m_dec(tcyc, shown)) begin errs++; $display("FAIL dec_conv t=%0d got %0d want %0d", tcyc, bus.oDecimal, m_dec(tcyc, shown)); end
         bus.iValid = drop_mid && (k == 2);
         if (drop_mid && k == 2) bus.iData = 8'd45;
         @(posedge iClk);
      end
      @(negedge iClk);
      shown = v;
      vecs++; if (bus.oDone !== 1'b1) begin errs++; $display("FAIL done v=%0d got %b want 1", v, bus.oDone); end
      vecs++; if (bus.oBusy !== 1'b0) begin errs++; $display("FAIL busy_end v=%0d got %b want 0", v, bus.oBusy); end
      vecs++; if (bus.oDigitSel !== m_sel(tcyc, shown)) begin errs++; $display("FAIL sel_done t=%0d got %b want %b", tcyc, bus.oDigitSel, m_sel(tcyc, shown)); end
      vecs++; if (bus.oDecimal !== m_dec(tcyc, shown)) begin errs++; $display("FAIL dec_done t=%0d got %0d want %0d", tcyc, bus.oDecimal, m_dec(tcyc, shown)); end
      bus.iValid = drop_done;
      if (drop_done) bus.iData = 8'd45;
      @(posedge iClk);
      @(negedge iClk);
      bus.iValid = 1'b0;
      vecs++; if (bus.oDone !== 1'b0) begin errs++; $display("FAIL done_once v=%0d got %b want 0", v, bus.oDone); end
      vecs++; if (bus.oBusy !== 1'b0) begin errs++; $display("FAIL drop_done v=%0d got %b want 0", v, bus.oBusy); end
   endtask

   task automatic scan_watch(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge iClk);
         vecs++; if (bus.oDigitSel !== m_sel(tcyc, shown)) begin errs++; $display("FAIL sel t=%0d v=%0d got %b want %b", tcyc, shown, bus.oDigitSel, m_sel(tcyc, shown)); end
         vecs++; if (bus.oDecimal !== m_dec(tcyc, shown)) begin errs++; $display("FAIL dec t=%0d v=%0d got %0d want %0d", tcyc, shown, bus.oDecimal, m_dec(tcyc, shown)); end
         vecs++; if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) begin errs++; $display("FAIL idle t=%0d got done=%b busy=%b want 0/0", tcyc, bus.oDone, bus.oBusy); end
      end
   endtask

   task automatic test_reset;
      iRst = 1'b1; bus.iValid = 1'b0; bus.iData = 8'd0;
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      iRst = 1'b0; shown = 0;
      vecs++; if (bus.oDigitSel !== 3'b110) begin errs++; $display("FAIL rst_sel got %b want 110", bus.oDigitSel); end
      vecs++; if (bus.oDecimal !== 4'd0) begin errs++; $display("FAIL rst_dec got %0d want 0", bus.oDecimal); end
      vecs++; if (bus.oBusy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", bus.oBusy); end
      vecs++; if (bus.oDone !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", bus.oDone); end
      scan_watch(24);
   endtask

   task automatic test_max;
      run_conv(8'd255, 1'b0, 1'b0);
      scan_watch(12);
   endtask

   task automatic test_zero_hundred;
      run_conv(8'd0, 1'b0, 1'b0);
      scan_watch(12);
      run_conv(8'd100, 1'b0, 1'b0);
      scan_watch(12);
   endtask

   task automatic test_drop;
      run_conv(8'd123, 1'b1, 1'b1);
      scan_watch(12);
   endtask

   task automatic test_reset_abort;
      @(negedge iClk);
      bus.iData = 8'd77; bus.iValid = 1'b1;
      @(posedge iClk);
      @(negedge iClk);
      bus.iValid = 1'b0;
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      iRst = 1'b1;
      @(posedge iClk);
      @(negedge iClk);
      iRst = 1'b0; shown = 0;
      vecs++; if (bus.oBusy !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", bus.oBusy); end
      vecs++; if (bus.oDigitSel !== 3'b110) begin errs++; $display("FAIL abort_sel got %b want 110", bus.oDigitSel); end
      vecs++; if (bus.oDecimal !== 4'd0) begin errs++; $display("FAIL abort_dec got %0d want 0", bus.oDecimal); end
      scan_watch(16);
   endtask

   task automatic test_blank;
      run_conv(8'd7, 1'b0, 1'b0);
      scan_watch(12);
      run_conv(8'd40, 1'b0, 1'b0);
      scan_watch(12);
   endtask

   task automatic test_random;
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge iClk);
         run_conv(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         scan_watch($urandom_range(3, 12));
      end
   endtask

   initial begin
      bus.iValid = 1'b0;
      bus.iData  = 8'd0;
      test_reset();
      test_max();
      test_zero_hundred();
      test_drop();
      test_reset_abort();
      test_blank();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
